// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the IO scratchpad responder: message layout,
// size decode, byte-lane masks and error causes.
package bp_me_pkg;

  localparam int paddr_width_p  = 40;
  localparam int dword_width_p  = 64;
  localparam int lce_id_width_p = 4;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4,
    e_cce_mem_amo   = 4'd5
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [11:0]               way_tag;
  } bp_cce_io_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e      msg_type;
    logic [paddr_width_p-1:0]  addr;
    bp_mem_msg_size_e          size;
    bp_cce_io_payload_s        payload;
  } bp_cce_io_msg_header_s;

  typedef struct packed {
    bp_cce_io_msg_header_s     header;
    logic [dword_width_p-1:0]  data;
  } bp_cce_io_msg_s;

  typedef enum logic [1:0] {e_ok, e_range, e_align, e_op} bp_me_err_e;

  // Sizes above a dword are rejected by the decoder; they map to 8 here.
  function automatic logic [3:0] size_to_bytes(input bp_mem_msg_size_e s);
    case (s)
      e_mem_msg_size_1: size_to_bytes = 4'd1;
      e_mem_msg_size_2: size_to_bytes = 4'd2;
      e_mem_msg_size_4: size_to_bytes = 4'd4;
      default:          size_to_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input bp_mem_msg_size_e s, input logic [2:0] off);
    logic [15:0] m;
    m = ((16'd1 << size_to_bytes(s)) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] mask_expand(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

endpackage

// File: rtl/bp_me_scratchpad_mem.sv
// Dword array with synchronous byte-masked write and asynchronous read.
module bp_me_scratchpad_mem #(
  parameter int els_p   = 64,
  parameter int width_p = 64,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   w_v_i,
  input  logic [lg_els_lp-1:0]   w_addr_i,
  input  logic [width_p-1:0]     w_data_i,
  input  logic [width_p/8-1:0]   w_mask_i,
  input  logic [lg_els_lp-1:0]   r_addr_i,
  output logic [width_p-1:0]     r_data_o
);

  logic [width_p-1:0] r_mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i)
      for (int b = 0; b < width_p/8; b++)
        if (w_mask_i[b]) r_mem[w_addr_i][8*b +: 8] <= w_data_i[8*b +: 8];
  end

  assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bp_me_io_scratchpad_responder.sv
// Terminates uncached IO commands against a local dword scratchpad and
// returns one response per command through a single-entry buffer.
module bp_me_io_scratchpad_responder
  import bp_me_pkg::*;
#(
  parameter int                       els_p       = 64,
  parameter logic [paddr_width_p-1:0] base_addr_p = paddr_width_p'(32'h0010_0000)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  bp_cce_io_msg_s io_cmd_i,
  input  logic           io_cmd_v_i,
  output logic           io_cmd_yumi_o,
  output bp_cce_io_msg_s io_resp_o,
  output logic           io_resp_v_o,
  input  logic           io_resp_ready_i,
  output logic           err_o,
  output logic [31:0]    cmd_count_o
);

  localparam int lg_els_lp = $clog2(els_p);

  logic                     r_resp_full;
  bp_cce_io_msg_s           r_resp;
  logic                     r_err;
  logic [31:0]              r_count;

  logic [paddr_width_p-1:0] w_offset;
  logic                     w_in_range;
  logic [lg_els_lp-1:0]     w_idx;
  logic [2:0]               w_byte_off;
  logic [3:0]               w_nbytes;
  logic                     w_is_rd, w_is_wr, w_size_ok;
  bp_me_err_e               w_cause;
  logic [63:0]              w_mem_rdata, w_rd_data, w_wdata;
  logic [7:0]               w_wmask;
  logic                     w_mem_wv;
  bp_cce_io_msg_s           w_resp;

  // Yumi may replace the buffered response in the cycle it is dequeued.
  assign io_cmd_yumi_o = io_cmd_v_i & ~reset_i & (~r_resp_full | (r_resp_full & io_resp_ready_i));

  assign w_offset   = io_cmd_i.header.addr - base_addr_p;
  assign w_in_range = (io_cmd_i.header.addr >= base_addr_p)
                    && (w_offset < paddr_width_p'(els_p*8));
  assign w_idx      = w_offset[3 +: lg_els_lp];
  assign w_byte_off = w_offset[2:0];
  assign w_nbytes   = size_to_bytes(io_cmd_i.header.size);
  assign w_is_rd    = (io_cmd_i.header.msg_type == e_cce_mem_uc_rd);
  assign w_is_wr    = (io_cmd_i.header.msg_type == e_cce_mem_uc_wr);
  assign w_size_ok  = (io_cmd_i.header.size <= e_mem_msg_size_8);

  always_comb begin
    w_cause = e_ok;
    if (!(w_is_rd || w_is_wr) || !w_size_ok)               w_cause = e_op;
    else if (!w_in_range)                                  w_cause = e_range;
    else if ((w_byte_off & 3'(w_nbytes - 4'd1)) != 3'd0)   w_cause = e_align;
  end

  assign w_mem_wv = io_cmd_yumi_o & w_is_wr & (w_cause == e_ok);
  assign w_wmask  = byte_mask(io_cmd_i.header.size, w_byte_off);
  assign w_wdata  = io_cmd_i.data << {w_byte_off, 3'b000};

  bp_me_scratchpad_mem #(.els_p(els_p), .width_p(64)) mem (
    .clk_i    (clk_i),
    .w_v_i    (w_mem_wv),
    .w_addr_i (w_idx),
    .w_data_i (w_wdata),
    .w_mask_i (w_wmask),
    .r_addr_i (w_idx),
    .r_data_o (w_mem_rdata)
  );

  assign w_rd_data = (w_mem_rdata >> {w_byte_off, 3'b000})
                   & mask_expand(byte_mask(io_cmd_i.header.size, 3'd0));

  always_comb begin
    w_resp        = '0;
    w_resp.header = io_cmd_i.header;
    w_resp.data   = (w_is_rd && (w_cause == e_ok)) ? w_rd_data : 64'd0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_resp_full <= 1'b0;
      r_resp      <= '0;
      r_err       <= 1'b0;
      r_count     <= 32'd0;
    end else begin
      if (io_cmd_yumi_o) begin
        r_resp_full <= 1'b1;
        r_resp      <= w_resp;
        r_count     <= r_count + 32'd1;
        if (w_cause != e_ok) r_err <= 1'b1;
      end else if (r_resp_full && io_resp_ready_i) begin
        r_resp_full <= 1'b0;
      end
    end
  end

  assign io_resp_o   = r_resp;
  assign io_resp_v_o = r_resp_full;
  assign err_o       = r_err;
  assign cmd_count_o = r_count;

endmodule

// File: tb/tb_bp_me_io_scratchpad_responder.sv
// Directed bench for the IO scratchpad responder.
module tb_bp_me_io_scratchpad_responder;
  import bp_me_pkg::*;

  localparam logic [39:0] BASE = 40'h10_0000;
  localparam int          ELS  = 64;

  logic           clk, reset_i;
  bp_cce_io_msg_s io_cmd_i, io_resp_o;
  logic           io_cmd_v_i, io_cmd_yumi_o, io_resp_v_o, io_resp_ready_i, err_o;
  logic [31:0]    cmd_count_o;

  int n_chk = 0, n_fail = 0;

  bp_me_io_scratchpad_responder #(.els_p(ELS), .base_addr_p(BASE)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i),
    .err_o(err_o), .cmd_count_o(cmd_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bp_cce_io_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                        input bp_mem_msg_size_e s, input logic [15:0] p,
                                        input logic [63:0] d);
    bp_cce_io_msg_s m;
    m.header.msg_type = t;
    m.header.addr     = a;
    m.header.size     = s;
    m.header.payload  = p;
    m.data            = d;
    return m;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with v low.
  task automatic send(input bp_cce_io_msg_s c);
    int n;
    io_cmd_i = c; io_cmd_v_i = 1'b1; n = 0;
    #1;
    while (!io_cmd_yumi_o && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("yumi_timeout", 64'd0, 64'd1);
    @(negedge clk);
    io_cmd_v_i = 1'b0;
    #1;
  endtask

  task automatic exp_resp(input string tag, input bp_cce_io_msg_s c, input logic [63:0] d);
    chk({tag, "_v"},    64'(io_resp_v_o), 64'd1);
    chk({tag, "_data"}, io_resp_o.data, d);
    chk({tag, "_addr"}, 64'(io_resp_o.header.addr), 64'(c.header.addr));
    chk({tag, "_type"}, 64'(io_resp_o.header.msg_type), 64'(c.header.msg_type));
    chk({tag, "_size"}, 64'(io_resp_o.header.size), 64'(c.header.size));
    chk({tag, "_pl"},   64'(io_resp_o.header.payload), 64'(c.header.payload));
  endtask

  bp_cce_io_msg_s c;
  int yumis, sent, rcvd, cyc;

  initial begin
    reset_i = 1'b1; io_cmd_v_i = 1'b0; io_resp_ready_i = 1'b1;
    io_cmd_i = mk(e_cce_mem_uc_rd, BASE, e_mem_msg_size_8, 16'h0, 64'h0);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("rst_resp_v", 64'(io_resp_v_o), 64'd0);
    chk("rst_yumi",   64'(io_cmd_yumi_o), 64'd0);
    chk("rst_err",    64'(err_o), 64'd0);
    chk("rst_count",  64'(cmd_count_o), 64'd0);
    chk("rst_resp",   io_resp_o.data | 64'(io_resp_o.header.addr), 64'd0);

    // full-dword write then readback
    c = mk(e_cce_mem_uc_wr, BASE + 40'h8, e_mem_msg_size_8, 16'h0011, 64'h1122334455667788);
    send(c); exp_resp("wr8", c, 64'd0);
    c = mk(e_cce_mem_uc_rd, BASE + 40'h8, e_mem_msg_size_8, 16'h0012, 64'hFFFF);
    send(c); exp_resp("rd8", c, 64'h1122334455667788);
    chk("rd8_err", 64'(err_o), 64'd0);

    // byte write; upper data bits must be ignored
    c = mk(e_cce_mem_uc_wr, BASE + 40'hD, e_mem_msg_size_1, 16'h0013, 64'hFFFF_FFFF_FFFF_FFAB);
    send(c); exp_resp("wr1", c, 64'd0);
    c = mk(e_cce_mem_uc_rd, BASE + 40'h8, e_mem_msg_size_8, 16'h0014, 64'h0);
    send(c); exp_resp("rd8b", c, 64'h1122AB4455667788);
    c = mk(e_cce_mem_uc_rd, BASE + 40'hC, e_mem_msg_size_2, 16'h0015, 64'h0);
    send(c); exp_resp("rd2", c, 64'h000000000000AB44);
    chk("count6", 64'(cmd_count_o), 64'd5);
    @(negedge clk);

    // backpressure: one acceptance, held response stable
    io_resp_ready_i = 1'b0;
    io_cmd_i = mk(e_cce_mem_uc_rd, BASE + 40'h8, e_mem_msg_size_8, 16'h0050, 64'h0);
    io_cmd_v_i = 1'b1;
    yumis = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (io_cmd_yumi_o) yumis++;
      if (k > 0) begin
        chk("bp_v",  64'(io_resp_v_o), 64'd1);
        chk("bp_pl", 64'(io_resp_o.header.payload), 64'h50);
        chk("bp_data", io_resp_o.data, 64'h1122AB4455667788);
      end
      @(negedge clk);
      io_cmd_i.header.payload = 16'h0051;
    end
    chk("bp_yumis", 64'(yumis), 64'd1);
    io_resp_ready_i = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      chk("b2b_v",    64'(io_resp_v_o), 64'd1);
      chk("b2b_pl",   64'(io_resp_o.header.payload), 64'(16'h50 + r));
      chk("b2b_yumi", 64'(io_cmd_yumi_o), 64'd1);
      @(negedge clk);
      io_cmd_i.header.payload = 16'(16'h52 + r);
    end
    io_cmd_v_i = 1'b0;
    #1;
    chk("b2b_last", 64'(io_resp_o.header.payload), 64'h53);
    @(negedge clk); #1;
    chk("b2b_empty", 64'(io_resp_v_o), 64'd0);
    chk("b2b_err", 64'(err_o), 64'd0);

    // invalid commands
    c = mk(e_cce_mem_uc_rd, BASE + 40'hA, e_mem_msg_size_4, 16'h0060, 64'h0);
    send(c); exp_resp("mis_rd", c, 64'd0);
    chk("mis_err", 64'(err_o), 64'd1);
    c = mk(e_cce_mem_uc_wr, BASE + 40'h9, e_mem_msg_size_2, 16'h0061, 64'hFFFF);
    send(c); exp_resp("mis_wr", c, 64'd0);
    c = mk(e_cce_mem_uc_rd, BASE + 40'h8, e_mem_msg_size_8, 16'h0062, 64'h0);
    send(c); exp_resp("mis_chk", c, 64'h1122AB4455667788);
    c = mk(e_cce_mem_uc_wr, BASE, e_mem_msg_size_8, 16'h0063, 64'h0102030405060708);
    send(c);
    c = mk(e_cce_mem_uc_wr, BASE + 40'(ELS*8), e_mem_msg_size_8, 16'h0064, 64'hDEADBEEFDEADBEEF);
    send(c); exp_resp("oor_wr", c, 64'd0);
    c = mk(e_cce_mem_uc_rd, BASE, e_mem_msg_size_8, 16'h0065, 64'h0);
    send(c); exp_resp("oor_chk", c, 64'h0102030405060708);
    c = mk(e_cce_mem_uc_rd, BASE + 40'(ELS*8), e_mem_msg_size_8, 16'h0066, 64'h0);
    send(c); exp_resp("oor_rd", c, 64'd0);
    c = mk(e_cce_mem_rd, BASE + 40'h8, e_mem_msg_size_8, 16'h0067, 64'h0);
    send(c); exp_resp("op_rd", c, 64'd0);
    chk("err_sticky", 64'(err_o), 64'd1);

    // reset, then stream with random ready
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("rst2_err",   64'(err_o), 64'd0);
    chk("rst2_count", 64'(cmd_count_o), 64'd0);
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 100 && cyc < 3000) begin
      @(negedge clk); cyc++;
      io_resp_ready_i = ($urandom_range(0, 3) != 0);
      io_cmd_v_i = (sent < 100);
      io_cmd_i = mk(e_cce_mem_uc_rd, BASE + 40'h8, e_mem_msg_size_8, 16'(sent), 64'h0);
      #1;
      if (io_resp_v_o && io_resp_ready_i) begin
        chk("strm_pl",   64'(io_resp_o.header.payload), 64'(rcvd));
        chk("strm_data", io_resp_o.data, 64'h1122AB4455667788);
        rcvd++;
      end
      if (io_cmd_yumi_o) sent++;
    end
    chk("strm_rcvd", 64'(rcvd), 64'd100);
    io_cmd_v_i = 1'b0; io_resp_ready_i = 1'b1;
    @(negedge clk); #1;
    chk("strm_count", 64'(cmd_count_o), 64'd100);
    chk("strm_empty", 64'(io_resp_v_o), 64'd0);

    // reset one cycle after an accepted write
    @(negedge clk);
    io_resp_ready_i = 1'b0;
    io_cmd_i = mk(e_cce_mem_uc_wr, BASE + 40'h10, e_mem_msg_size_8, 16'h0077, 64'hCAFEF00D12345678);
    io_cmd_v_i = 1'b1;
    #1;
    chk("mr_yumi", 64'(io_cmd_yumi_o), 64'd1);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("mr_pending", 64'(io_resp_v_o), 64'd1);
    chk("mr_blocked", 64'(io_cmd_yumi_o), 64'd0);
    @(negedge clk);
    io_cmd_v_i = 1'b0; reset_i = 1'b0; io_resp_ready_i = 1'b1;
    #1;
    chk("mr_resp_v", 64'(io_resp_v_o), 64'd0);
    chk("mr_count",  64'(cmd_count_o), 64'd0);
    chk("mr_data0",  io_resp_o.data, 64'd0);
    c = mk(e_cce_mem_uc_rd, BASE + 40'h10, e_mem_msg_size_8, 16'h0078, 64'h0);
    send(c); exp_resp("mr_rd", c, 64'hCAFEF00D12345678);
    chk("mr_count1", 64'(cmd_count_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
